// File: rtl/imu_pkg.sv
// Shared types and constants for the IMU transaction sequencer.
package imu_pkg;

   typedef enum logic [3:0] {
      StBoot,
      StIdIssue,
      StIdWait,
      StCfgIssue,
      StCfgWait,
      StIdle,
      StRdIssue,
      StRdWait,
      StPublish,
      StError
   } imu_state_t;

   localparam logic [7:0] REG_WHO_AM_I = 8'h0F;
   localparam logic [7:0] REG_CTRL1_XL = 8'h10;
   localparam logic [7:0] REG_CTRL2_G  = 8'h11;
   localparam logic [7:0] REG_CTRL3_C  = 8'h12;
   localparam logic [7:0] REG_OUT_BASE = 8'h22;

   localparam int unsigned OUT_BYTES    = 12;
   localparam logic [3:0]  OUT_LAST_IDX = 4'(OUT_BYTES - 1);
   localparam int unsigned CFG_ENTRIES  = 3;
   localparam logic [3:0]  CFG_LAST_IDX = 4'(CFG_ENTRIES - 1);

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } cfg_entry_t;

   // Sensor configuration table, written in index order after the ID check.
   function automatic cfg_entry_t cfg_entry(input logic [3:0] idx);
      cfg_entry_t e;
      case (idx)
         4'd0:    e = '{addr: REG_CTRL1_XL, data: 8'h40};
         4'd1:    e = '{addr: REG_CTRL2_G,  data: 8'h40};
         default: e = '{addr: REG_CTRL3_C,  data: 8'h44};
      endcase
      return e;
   endfunction

endpackage

// File: rtl/imu_sample_timer.sv
// Free-running period counter; one-cycle tick every Period cycles while enabled.
module imu_sample_timer #(
   parameter int unsigned Period = 25000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic en_i,
   output logic tick_o
);

   localparam int unsigned CntW = (Period > 1) ? $clog2(Period) : 1;
   localparam logic [CntW-1:0] LastCnt = CntW'(Period - 1);

   logic [CntW-1:0] cnt_q;

   // Count while enabled; restart from zero whenever the enable drops.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         cnt_q <= '0;
      end else if (!en_i) begin
         cnt_q <= '0;
      end else if (cnt_q == LastCnt) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Tick on the last count of each period.
   always_comb begin
      tick_o = en_i && (cnt_q == LastCnt);
   end

endmodule

// File: rtl/imu_ctrl.sv
// IMU transaction sequencer: ID check, configuration writes, periodic 12-byte sample reads.
module imu_ctrl
   import imu_pkg::*;
#(
   parameter int unsigned BOOT_CYCLES   = 50000,
   parameter int unsigned SAMPLE_PERIOD = 25000,
   parameter logic [7:0]  WHO_AM_I_VAL  = 8'h6C,
   parameter int unsigned MAX_RETRIES   = 3
) (
   input  logic               clk,
   input  logic               reset_n,
   output logic [7:0]         spi_addr,
   output logic [7:0]         spi_wdata,
   output logic               spi_read,
   output logic               spi_enable,
   input  logic [7:0]         spi_rdata,
   input  logic               spi_done,
   output logic signed [15:0] gyro_x,
   output logic signed [15:0] gyro_y,
   output logic signed [15:0] gyro_z,
   output logic signed [15:0] accel_x,
   output logic signed [15:0] accel_y,
   output logic signed [15:0] accel_z,
   output logic               sample_valid,
   output logic               init_done,
   output logic               error,
   output logic               overrun
);

   imu_state_t  state_q;
   logic [31:0] boot_cnt_q;
   logic [31:0] retry_q;
   logic [3:0]  idx_q;
   logic [3:0]  idx_nxt;
   logic [7:0]  shadow_q [OUT_BYTES];
   cfg_entry_t  cfg_nxt;
   logic        tick;

   logic [7:0]  spi_addr_q, spi_wdata_q;
   logic        spi_read_q, spi_enable_q;
   logic [15:0] gyro_x_q, gyro_y_q, gyro_z_q;
   logic [15:0] accel_x_q, accel_y_q, accel_z_q;
   logic        sample_valid_q, init_done_q, error_q, overrun_q;

   imu_sample_timer #(
      .Period(SAMPLE_PERIOD)
   ) u_timer (
      .clk    (clk),
      .reset_n(reset_n),
      .en_i   (init_done_q),
      .tick_o (tick)
   );

   // Next byte index and the configuration entry it selects.
   always_comb begin
      idx_nxt = idx_q + 4'd1;
      cfg_nxt = cfg_entry(idx_nxt);
   end

   // Sequencer FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q        <= StBoot;
         boot_cnt_q     <= '0;
         retry_q        <= '0;
         idx_q          <= '0;
         spi_addr_q     <= '0;
         spi_wdata_q    <= '0;
         spi_read_q     <= 1'b0;
         spi_enable_q   <= 1'b0;
         gyro_x_q       <= '0;
         gyro_y_q       <= '0;
         gyro_z_q       <= '0;
         accel_x_q      <= '0;
         accel_y_q      <= '0;
         accel_z_q      <= '0;
         sample_valid_q <= 1'b0;
         init_done_q    <= 1'b0;
         error_q        <= 1'b0;
         overrun_q      <= 1'b0;
         for (int i = 0; i < OUT_BYTES; i++) begin
            shadow_q[i] <= '0;
         end
      end else begin
         spi_enable_q   <= 1'b0;
         sample_valid_q <= 1'b0;
         // A tick can only be taken in IDLE; anywhere else it is dropped.
         overrun_q      <= tick && (state_q != StIdle);

         case (state_q)
            StBoot: begin
               if (boot_cnt_q == BOOT_CYCLES - 1) begin
                  boot_cnt_q   <= '0;
                  spi_addr_q   <= REG_WHO_AM_I;
                  spi_wdata_q  <= '0;
                  spi_read_q   <= 1'b1;
                  spi_enable_q <= 1'b1;
                  state_q      <= StIdIssue;
               end else begin
                  boot_cnt_q <= boot_cnt_q + 32'd1;
               end
            end
            StIdIssue: state_q <= StIdWait;
            StIdWait: begin
               if (spi_done) begin
                  if (spi_rdata == WHO_AM_I_VAL) begin
                     idx_q        <= '0;
                     spi_addr_q   <= cfg_entry(4'd0).addr;
                     spi_wdata_q  <= cfg_entry(4'd0).data;
                     spi_read_q   <= 1'b0;
                     spi_enable_q <= 1'b1;
                     state_q      <= StCfgIssue;
                  end else begin
                     retry_q <= retry_q + 32'd1;
                     if (retry_q + 32'd1 < MAX_RETRIES) begin
                        boot_cnt_q <= '0;
                        state_q    <= StBoot;
                     end else begin
                        error_q <= 1'b1;
                        state_q <= StError;
                     end
                  end
               end
            end
            StCfgIssue: state_q <= StCfgWait;
            StCfgWait: begin
               if (spi_done) begin
                  if (idx_q == CFG_LAST_IDX) begin
                     idx_q       <= '0;
                     init_done_q <= 1'b1;
                     state_q     <= StIdle;
                  end else begin
                     idx_q        <= idx_nxt;
                     spi_addr_q   <= cfg_nxt.addr;
                     spi_wdata_q  <= cfg_nxt.data;
                     spi_enable_q <= 1'b1;
                     state_q      <= StCfgIssue;
                  end
               end
            end
            StIdle: begin
               if (tick) begin
                  idx_q        <= '0;
                  spi_addr_q   <= REG_OUT_BASE;
                  spi_wdata_q  <= '0;
                  spi_read_q   <= 1'b1;
                  spi_enable_q <= 1'b1;
                  state_q      <= StRdIssue;
               end
            end
            StRdIssue: state_q <= StRdWait;
            StRdWait: begin
               if (spi_done) begin
                  shadow_q[idx_q] <= spi_rdata;
                  if (idx_q == OUT_LAST_IDX) begin
                     state_q <= StPublish;
                  end else begin
                     idx_q        <= idx_nxt;
                     spi_addr_q   <= REG_OUT_BASE + {4'd0, idx_nxt};
                     spi_enable_q <= 1'b1;
                     state_q      <= StRdIssue;
                  end
               end
            end
            StPublish: begin
               gyro_x_q       <= {shadow_q[1],  shadow_q[0]};
               gyro_y_q       <= {shadow_q[3],  shadow_q[2]};
               gyro_z_q       <= {shadow_q[5],  shadow_q[4]};
               accel_x_q      <= {shadow_q[7],  shadow_q[6]};
               accel_y_q      <= {shadow_q[9],  shadow_q[8]};
               accel_z_q      <= {shadow_q[11], shadow_q[10]};
               sample_valid_q <= 1'b1;
               idx_q          <= '0;
               state_q        <= StIdle;
            end
            StError: state_q <= StError;
            default: state_q <= StBoot;
         endcase
      end
   end

   // Drive ports straight from their registers.
   always_comb begin
      spi_addr     = spi_addr_q;
      spi_wdata    = spi_wdata_q;
      spi_read     = spi_read_q;
      spi_enable   = spi_enable_q;
      gyro_x       = gyro_x_q;
      gyro_y       = gyro_y_q;
      gyro_z       = gyro_z_q;
      accel_x      = accel_x_q;
      accel_y      = accel_y_q;
      accel_z      = accel_z_q;
      sample_valid = sample_valid_q;
      init_done    = init_done_q;
      error        = error_q;
      overrun      = overrun_q;
   end

endmodule

// File: tb/tb_imu_ctrl.sv
// Bench for imu_ctrl: SPI engine BFM, byte-level sample model, directed phases.
module tb_imu_ctrl;

   localparam int unsigned BOOT   = 4;
   localparam int unsigned PERIOD = 600;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic [7:0]  spi_addr, spi_wdata, spi_rdata;
   logic        spi_read, spi_enable, spi_done;
   logic [15:0] gyro_x, gyro_y, gyro_z, accel_x, accel_y, accel_z;
   logic        sample_valid, init_done, error, overrun;

   imu_ctrl #(
      .BOOT_CYCLES  (BOOT),
      .SAMPLE_PERIOD(PERIOD),
      .WHO_AM_I_VAL (8'h6C),
      .MAX_RETRIES  (3)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .spi_addr    (spi_addr),
      .spi_wdata   (spi_wdata),
      .spi_read    (spi_read),
      .spi_enable  (spi_enable),
      .spi_rdata   (spi_rdata),
      .spi_done    (spi_done),
      .gyro_x      (gyro_x),
      .gyro_y      (gyro_y),
      .gyro_z      (gyro_z),
      .accel_x     (accel_x),
      .accel_y     (accel_y),
      .accel_z     (accel_z),
      .sample_valid(sample_valid),
      .init_done   (init_done),
      .error       (error),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- SPI engine BFM ----------------
   typedef struct {
      logic [7:0] addr;
      logic [7:0] wdata;
      logic       rd;
      int         cyc;
   } txn_t;

   txn_t       log_q[$];
   int         lat = 1;
   logic [7:0] seed = 8'h10;
   bit         id_ok = 1'b0;
   logic [7:0] exp_bytes [12];
   int         last_done_cyc = 0;

   function automatic logic [7:0] bfm_data(input logic [7:0] a);
      if (a == 8'h0F) return id_ok ? 8'h6C : 8'h00;
      return a + seed;
   endfunction

   initial begin
      txn_t t;
      bit   aborted;
      int   l;
      spi_done  = 1'b0;
      spi_rdata = 8'h00;
      forever begin
         @(posedge clk); #1;
         while (reset_n && spi_enable) begin
            t.addr  = spi_addr;
            t.wdata = spi_wdata;
            t.rd    = spi_read;
            t.cyc   = cyc;
            log_q.push_back(t);
            aborted = 1'b0;
            l = lat;
            for (int i = 0; i < l; i++) begin
               @(posedge clk); #1;
               if (!reset_n) begin
                  aborted = 1'b1;
                  break;
               end
               chk("hs_enable_one_cycle", spi_enable, 1'b0);
               chk("hs_addr_stable", spi_addr, t.addr);
               chk("hs_wdata_stable", spi_wdata, t.wdata);
               chk("hs_read_stable", spi_read, t.rd);
            end
            if (!aborted) begin
               spi_rdata = t.rd ? bfm_data(t.addr) : 8'h00;
               if (t.rd && t.addr >= 8'h22 && t.addr <= 8'h2D)
                  exp_bytes[t.addr - 8'h22] = spi_rdata;
               spi_done = 1'b1;
               last_done_cyc = cyc;
               @(posedge clk); #1;
               spi_done = 1'b0;
            end
         end
      end
   end

   // ---------------- per-cycle output model ----------------
   logic [15:0] held [6];
   bit          prev_valid = 1'b0;
   bit          prev_init  = 1'b0;
   int          sv_cnt = 0;
   int          ov_cnt = 0;
   int          init_rise = -1;

   always @(negedge clk) begin
      logic [15:0] act_s [6];
      logic [15:0] exp_s;
      if (!reset_n) begin
         for (int k = 0; k < 6; k++) held[k] = 16'h0;
         prev_valid = 1'b0;
         prev_init  = 1'b0;
      end else begin
         act_s = '{gyro_x, gyro_y, gyro_z, accel_x, accel_y, accel_z};
         if (sample_valid) begin
            chk("sample_valid_single", prev_valid, 1'b0);
            for (int k = 0; k < 6; k++) begin
               exp_s = {exp_bytes[2*k+1], exp_bytes[2*k]};
               chk($sformatf("publish_sample%0d", k), act_s[k], exp_s);
               held[k] = exp_s;
            end
            sv_cnt++;
         end else begin
            for (int k = 0; k < 6; k++)
               chk($sformatf("hold_sample%0d", k), act_s[k], held[k]);
         end
         if (overrun) ov_cnt++;
         if (init_done && !prev_init) init_rise = cyc;
         if (error) chk("error_no_spi", spi_enable, 1'b0);
         prev_valid = sample_valid;
         prev_init  = init_done;
      end
   end

   // ---------------- helpers ----------------
   task automatic chk_zero(input string tag);
      chk({tag, "_spi_addr"}, spi_addr, 8'h0);
      chk({tag, "_spi_wdata"}, spi_wdata, 8'h0);
      chk({tag, "_spi_read"}, spi_read, 1'b0);
      chk({tag, "_spi_enable"}, spi_enable, 1'b0);
      chk({tag, "_gyro_x"}, gyro_x, 16'h0);
      chk({tag, "_gyro_y"}, gyro_y, 16'h0);
      chk({tag, "_gyro_z"}, gyro_z, 16'h0);
      chk({tag, "_accel_x"}, accel_x, 16'h0);
      chk({tag, "_accel_y"}, accel_y, 16'h0);
      chk({tag, "_accel_z"}, accel_z, 16'h0);
      chk({tag, "_sample_valid"}, sample_valid, 1'b0);
      chk({tag, "_init_done"}, init_done, 1'b0);
      chk({tag, "_error"}, error, 1'b0);
      chk({tag, "_overrun"}, overrun, 1'b0);
   endtask

   task automatic wait_valid(input string name, input int bound);
      bit seen = 1'b0;
      for (int i = 0; i < bound && !seen; i++) begin
         @(posedge clk); #1;
         if (sample_valid) seen = 1'b1;
      end
      chk(name, seen, 1'b1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // ---------------- directed phases ----------------
   initial begin
      int  rel;
      int  sv_a, sv_b, sv_c, sv_d;
      int  ov0, en0;
      bit  found;

      // Bad ID every time: three reads, each after a full boot wait, then ERROR.
      id_ok   = 1'b0;
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset");
      reset_n = 1'b1;
      rel = cyc;
      found = 1'b0;
      for (int i = 0; i < 200 && !found; i++) begin
         @(posedge clk); #1;
         if (error) found = 1'b1;
      end
      chk("t2_error_set", found, 1'b1);
      chk("t2_id_reads", log_q.size(), 3);
      for (int i = 0; i < 3 && i < log_q.size(); i++) begin
         chk("t2_id_addr", log_q[i].addr, 8'h0F);
         chk("t2_id_rd", log_q[i].rd, 1'b1);
      end
      if (log_q.size() >= 3) begin
         chk("t2_first_boot", log_q[0].cyc - rel, BOOT);
         chk("t2_retry_gap1", log_q[1].cyc - log_q[0].cyc, 2 + BOOT);
         chk("t2_retry_gap2", log_q[2].cyc - log_q[1].cyc, 2 + BOOT);
      end
      chk("t2_init_low", init_done, 1'b0);
      en0 = log_q.size();
      repeat (100) @(posedge clk);
      #1;
      chk("t2_no_more_spi", log_q.size(), en0);
      chk("t2_error_held", error, 1'b1);

      // Good ID with a spi_done glitch during BOOT.
      reset_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset2");
      log_q.delete();
      id_ok   = 1'b1;
      seed    = 8'h10;
      reset_n = 1'b1;
      rel = cyc;
      @(posedge clk); #1;
      spi_done = 1'b1;
      @(posedge clk); #1;
      spi_done = 1'b0;
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         @(posedge clk); #1;
         if (init_done) found = 1'b1;
      end
      chk("t1_init_done", found, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("t1_txn_count", log_q.size(), 4);
      if (log_q.size() >= 4) begin
         chk("t1_boot_ignores_glitch", log_q[0].cyc - rel, BOOT);
         chk("t1_id_addr", log_q[0].addr, 8'h0F);
         chk("t1_id_rd", log_q[0].rd, 1'b1);
         chk("t1_cfg0", {log_q[1].rd, log_q[1].addr, log_q[1].wdata}, {1'b0, 16'h1040});
         chk("t1_cfg1", {log_q[2].rd, log_q[2].addr, log_q[2].wdata}, {1'b0, 16'h1140});
         chk("t1_cfg2", {log_q[3].rd, log_q[3].addr, log_q[3].wdata}, {1'b0, 16'h1244});
      end
      chk("t1_init_timing", init_rise - last_done_cyc, 1);
      chk("t1_error_low", error, 1'b0);

      // spi_done glitch during IDLE.
      spi_done  = 1'b1;
      spi_rdata = 8'h6C;
      @(posedge clk); #1;
      spi_done = 1'b0;
      repeat (20) @(posedge clk);
      #1;
      chk("t6_idle_no_spi", log_q.size(), 4);
      chk("t6_idle_no_valid", sv_cnt, 0);
      chk("t6_idle_init_held", init_done, 1'b1);

      // First sample burst.
      wait_valid("t3_first_valid", 1000);
      sv_a = cyc;
      chk("t3_gyro_x", gyro_x, 16'h3332);
      chk("t3_gyro_y", gyro_y, 16'h3534);
      chk("t3_accel_z", accel_z, 16'h3D3C);
      @(posedge clk); #1;
      chk("t3_valid_one_cycle", sample_valid, 1'b0);
      chk("t3_txn_count", log_q.size(), 16);
      for (int i = 0; i < 12 && 4 + i < log_q.size(); i++) begin
         chk("t3_rd_addr", log_q[4+i].addr, 8'h22 + 8'(i));
         chk("t3_rd_rd", log_q[4+i].rd, 1'b1);
      end
      seed = 8'h20;
      wait_valid("t3_second_valid", 800);
      sv_b = cyc;
      chk("t3_period", sv_b - sv_a, PERIOD);
      chk("t3_gyro_x_2", gyro_x, 16'h4342);
      chk("t3_overrun_none", ov_cnt, 0);

      // Slow engine: burst longer than a period drops exactly one tick.
      lat = 60;
      ov0 = ov_cnt;
      wait_valid("t4_slow_valid", 2000);
      sv_c = cyc;
      lat = 1;
      wait_valid("t4_next_valid", 2000);
      sv_d = cyc;
      chk("t4_overrun_once", ov_cnt - ov0, 1);
      chk("t4_next_tick_gap", sv_d - sv_c, 2 * PERIOD - 12 * (60 - 1));
      chk("t4_accel_x", accel_x, 16'h4948);

      // Reset in the middle of a burst at idx 5.
      seed = 8'h50;
      found = 1'b0;
      for (int i = 0; i < 1000 && !found; i++) begin
         @(posedge clk); #1;
         if (spi_enable && spi_addr == 8'h27) found = 1'b1;
      end
      chk("t5_reached_idx5", found, 1'b1);
      reset_n = 1'b0;
      @(posedge clk); #1;
      chk_zero("t5_reset");
      repeat (2) @(posedge clk);
      #1;
      log_q.delete();
      seed    = 8'h60;
      reset_n = 1'b1;
      wait_valid("t5_restart_valid", 1000);
      chk("t5_first_is_id", (log_q.size() > 0) ? log_q[0].addr : 8'hFF, 8'h0F);
      chk("t5_txn_count", log_q.size(), 16);
      chk("t5_gyro_x", gyro_x, 16'h8382);
      chk("t5_accel_z", accel_z, 16'h8D8C);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
